// File: rtl/fb_scanout_arbiter_pkg.sv
// Shared display definitions for the framebuffer scanout arbiter: geometry
// defaults, colour packing, blank sentinel, clear FSM encoding, RAM command.
package fb_scanout_arbiter_pkg;

  localparam int FB_W_DEF       = 200;
  localparam int FB_H_DEF       = 150;
  localparam int SCALE_LOG2_DEF = 2;
  localparam int FB_AW          = 15;
  localparam int PIX_W          = 10;
  localparam int COLOR_W        = 12;

  // Colour word packing {r, g, b}
  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  localparam logic [PIX_W-1:0] BLANK_COORD = 10'h3FF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_e;

  typedef struct packed {
    logic               en;
    logic               we;
    logic [FB_AW-1:0]   addr;
    logic [COLOR_W-1:0] wdata;
  } ram_cmd_t;

  // Constant multiply as a sum of shifted copies (200 = 128 + 64 + 8).
  function automatic logic [FB_AW-1:0] mul_const(input logic [FB_AW-1:0] a,
                                                 input int unsigned      k);
    logic [FB_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < FB_AW; i++) begin
      if (k[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps display coordinates to a framebuffer word address and classifies the
// cycle as a fetch (first column of a scaled pixel) and/or blank.
module fb_addr_calc
  import fb_scanout_arbiter_pkg::*;
#(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF
) (
  input  logic [PIX_W-1:0] pixel_x,
  input  logic [PIX_W-1:0] pixel_y,
  output logic             fetch,
  output logic             blank,
  output logic [FB_AW-1:0] addr
);

  localparam logic [PIX_W:0]   X_LIM    = (PIX_W+1)'(FB_W << SCALE_LOG2);
  localparam logic [PIX_W:0]   Y_LIM    = (PIX_W+1)'(FB_H << SCALE_LOG2);
  localparam logic [PIX_W-1:0] SUB_MASK = PIX_W'((1 << SCALE_LOG2) - 1);

  logic             in_x;
  logic             in_y;
  logic [PIX_W-1:0] fb_x;
  logic [PIX_W-1:0] fb_y;

  // The blank sentinel is far beyond any legal extent, so the range check
  // alone covers it.
  always_comb begin
    in_x  = {1'b0, pixel_x} < X_LIM;
    in_y  = {1'b0, pixel_y} < Y_LIM;
    fb_x  = pixel_x >> SCALE_LOG2;
    fb_y  = pixel_y >> SCALE_LOG2;
    fetch = in_x && in_y && ((pixel_x & SUB_MASK) == '0);
    blank = !(in_x && in_y);
    addr  = mul_const(FB_AW'(fb_y), FB_W) + FB_AW'(fb_x);
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Shares one single-port framebuffer RAM between display fetches (highest
// priority), a hardware fill engine and game-logic writes; drives scanout colour.
module fb_scanout_arbiter
  import fb_scanout_arbiter_pkg::*;
#(
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PIX_W-1:0]    pixel_x,
  input  logic [PIX_W-1:0]    pixel_y,
  output logic [3:0]          out_r,
  output logic [3:0]          out_g,
  output logic [3:0]          out_b,
  input  logic                wr_req,
  input  logic [FB_AW-1:0]    wr_addr,
  input  logic [COLOR_W-1:0]  wr_data,
  output logic                wr_ack,
  input  logic                clear_req,
  input  logic [COLOR_W-1:0]  clear_color,
  output logic                clear_busy,
  output logic                ram_en,
  output logic                ram_we,
  output logic [FB_AW-1:0]    ram_addr,
  output logic [COLOR_W-1:0]  ram_wdata,
  input  logic [COLOR_W-1:0]  ram_rdata
);

  localparam int               FB_WORDS  = FB_W * FB_H;
  localparam logic [FB_AW:0]   WORDS_LIM = (FB_AW+1)'(FB_WORDS);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_WORDS - 1);

  logic             fetch;
  logic             blank;
  logic [FB_AW-1:0] fetch_addr;

  clear_state_e       state_q, state_d;
  logic [FB_AW-1:0]   clear_addr_q, clear_addr_d;
  logic [COLOR_W-1:0] clear_color_q, clear_color_d;

  ram_cmd_t cmd_q, cmd_d;
  logic     ack_q, ack_d;
  logic     write_ok;

  logic               s1_fetch_q, s1_blank_q;
  logic               s2_fetch_q, s2_blank_q;
  logic [COLOR_W-1:0] pix_q;

  fb_addr_calc #(
    .FB_W       (FB_W),
    .FB_H       (FB_H),
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_addr_calc (
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .fetch   (fetch),
    .blank   (blank),
    .addr    (fetch_addr)
  );

  // Clear FSM state and fill pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      clear_addr_q  <= '0;
      clear_color_q <= '0;
    end else begin
      state_q       <= state_d;
      clear_addr_q  <= clear_addr_d;
      clear_color_q <= clear_color_d;
    end
  end

  // Slot arbitration for the next cycle: fetch > fill > game write.
  // NOTE: every signal driven here gets a default first; a branch that skipped
  // one would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    clear_addr_d  = clear_addr_q;
    clear_color_d = clear_color_q;
    cmd_d         = '0;
    ack_d         = 1'b0;
    write_ok      = {1'b0, wr_addr} < WORDS_LIM;

    if (state_q == ST_IDLE && clear_req) begin
      state_d       = ST_CLEAR;
      clear_addr_d  = '0;
      clear_color_d = clear_color;
    end

    if (fetch) begin
      cmd_d.en   = 1'b1;
      cmd_d.addr = fetch_addr;
    end else if (state_q == ST_CLEAR) begin
      cmd_d.en     = 1'b1;
      cmd_d.we     = 1'b1;
      cmd_d.addr   = clear_addr_q;
      cmd_d.wdata  = clear_color_q;
      clear_addr_d = clear_addr_q + 1'b1;
      if (clear_addr_q == LAST_ADDR) state_d = ST_IDLE;
    end else if (state_q == ST_IDLE && !clear_req && wr_req && !ack_q) begin
      // An out-of-range write is acknowledged but never reaches the RAM.
      ack_d = 1'b1;
      if (write_ok) begin
        cmd_d.en    = 1'b1;
        cmd_d.we    = 1'b1;
        cmd_d.addr  = wr_addr;
        cmd_d.wdata = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
      ack_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      ack_q <= ack_d;
    end
  end

  // Two-stage {fetch, blank} pipeline lines up with the RAM read latency;
  // non-fetch active cycles hold the last colour to replicate scaled pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_fetch_q <= 1'b0;
      s1_blank_q <= 1'b0;
      s2_fetch_q <= 1'b0;
      s2_blank_q <= 1'b0;
      pix_q      <= '0;
    end else begin
      s1_fetch_q <= fetch;
      s1_blank_q <= blank;
      s2_fetch_q <= s1_fetch_q;
      s2_blank_q <= s1_blank_q;
      if (s2_fetch_q)      pix_q <= ram_rdata;
      else if (s2_blank_q) pix_q <= '0;
    end
  end

  assign out_r      = pix_q[R_MSB:R_LSB];
  assign out_g      = pix_q[G_MSB:G_LSB];
  assign out_b      = pix_q[B_MSB:B_LSB];
  assign wr_ack     = ack_q;
  assign clear_busy = (state_q == ST_CLEAR);
  assign ram_en     = cmd_q.en;
  assign ram_we     = cmd_q.we;
  assign ram_addr   = cmd_q.addr;
  assign ram_wdata  = cmd_q.wdata;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Scoreboard bench for fb_scanout_arbiter: behavioural RAM, frame-level colour
// model, queued expectations checked by an independent monitor.
module tb_fb_scanout_arbiter;
  import fb_scanout_arbiter_pkg::BLANK_COORD;

  localparam int W     = 200;
  localparam int H     = 150;
  localparam int SC    = 4;
  localparam int WORDS = W * H;
  localparam int BLANK = 1023;

  logic        clk;
  logic        reset_n;
  logic [9:0]  pixel_x, pixel_y;
  logic [3:0]  out_r, out_g, out_b;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        clear_busy;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  fb_scanout_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .out_r       (out_r),
    .out_g       (out_g),
    .out_b       (out_b),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- behavioural single-port RAM ----------------
  logic [11:0] mem [WORDS];
  int          wcount [WORDS];
  logic        preload_req = 1'b0;
  int          preload_seed = 0;

  function automatic logic [11:0] pat(input int a, input int seed);
    if (a == 201) return 12'hABC;
    return 12'((a * 37 + seed * 911) ^ (a >> 5));
  endfunction

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i]    <= pat(i, preload_seed);
        wcount[i] <= 0;
      end
    end else if (ram_en && int'(ram_addr) < WORDS) begin
      if (ram_we) begin
        mem[ram_addr]    <= ram_wdata;
        wcount[ram_addr] <= wcount[ram_addr] + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [11:0] ovr [int];
  bit          filled = 1'b0;
  logic [11:0] fill_col = '0;
  logic [11:0] last_rgb = '0;

  function automatic logic [11:0] ref_word(input int a);
    if (ovr.exists(a)) return ovr[a];
    if (filled) return fill_col;
    return pat(a, preload_seed);
  endfunction

  typedef struct {
    longint      due;
    logic [11:0] rgb;
  } pix_exp_t;

  typedef struct {
    int          addr;
    logic [11:0] data;
  } wr_exp_t;

  pix_exp_t pix_q[$];
  wr_exp_t  wr_q[$];

  int     total = 0;
  int     bad   = 0;
  longint last_ack_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic     prev_ack;
    logic     prev_busy;
    pix_exp_t pe;
    wr_exp_t  we;
    prev_ack  = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ack  = 1'b0;
        prev_busy = 1'b0;
      end else begin
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
          pe = pix_q.pop_front();
          check("scanout_rgb", {20'd0, out_r, out_g, out_b}, {20'd0, pe.rgb});
        end
        if (wr_ack) begin
          check("ack_gap", {31'd0, prev_ack}, 32'd0);
          check("ack_while_busy", {31'd0, clear_busy}, 32'd0);
          check("ack_has_request", {31'd0, wr_q.size() > 0}, 32'd1);
          if (wr_q.size() > 0) begin
            we = wr_q.pop_front();
            if (we.addr < WORDS) begin
              check("wr_en_we", {30'd0, ram_en, ram_we}, 32'd3);
              check("wr_addr", {17'd0, ram_addr}, we.addr);
              check("wr_data", {20'd0, ram_wdata}, {20'd0, we.data});
            end else begin
              check("drop_en_we", {30'd0, ram_en, ram_we}, 32'd0);
            end
          end
        end else if (ram_we) begin
          check("stray_write", {31'd0, clear_busy | prev_busy}, 32'd1);
        end
        prev_ack  = wr_ack;
        prev_busy = clear_busy;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input int seed);
    preload_seed = seed;
    ovr.delete();
    filled      = 1'b0;
    preload_req = 1'b1;
    @(posedge clk);
    #1 preload_req = 1'b0;
  endtask

  task automatic drive_pix(input int x, input int y);
    @(posedge clk);
    #1;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    if (x >= W * SC || y >= H * SC) last_rgb = '0;
    else if (x % SC == 0)           last_rgb = ref_word((y / SC) * W + x / SC);
    pix_q.push_back('{cyc + 3, last_rgb});
  endtask

  task automatic blank_cycles(input int n);
    for (int i = 0; i < n; i++) drive_pix(BLANK, BLANK);
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (wr_ack) break;
      n++;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL ack_timeout: no wr_ack within %0d cycles", budget);
        break;
      end
    end
    last_ack_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int addr, input logic [11:0] data, input int budget);
    wr_req  = 1'b1;
    wr_addr = 15'(addr);
    wr_data = data;
    wr_q.push_back('{addr, data});
    if (addr < WORDS) ovr[addr] = data;
    wait_ack(budget);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int          addrs [6];
    logic [11:0] datas [6];
    longint      first_ack;
    int          busy_cycles;
    longint      fall_cyc;
    int          mism;
    int          base;

    reset_n     = 1'b0;
    pixel_x     = BLANK_COORD;
    pixel_y     = BLANK_COORD;
    wr_req      = 1'b1;
    wr_addr     = 15'd7;
    wr_data     = 12'h777;
    clear_req   = 1'b0;
    clear_color = '0;
    preload(1);
    wr_q.push_back('{7, 12'h777});
    ovr[7] = 12'h777;

    // Reset holds every output at zero even with a pending request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 32'd0);
    check("rst_ack", {31'd0, wr_ack}, 32'd0);
    check("rst_out", {20'd0, out_r, out_g, out_b}, 32'd0);
    check("rst_busy", {31'd0, clear_busy}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("ack_after_reset", {31'd0, wr_ack}, 32'd0);
    wait_ack(10);
    wr_req = 1'b0;

    // Scanout latency on word 201 (x=4..7, y=4), then blank.
    blank_cycles(4);
    drive_pix(4, 4);
    drive_pix(5, 4);
    @(negedge clk);
    check("fetch_ram_addr", {17'd0, ram_addr}, 32'd201);
    check("fetch_en_we", {30'd0, ram_en, ram_we}, 32'd2);
    drive_pix(6, 4);
    drive_pix(7, 4);
    blank_cycles(5);

    // Randomized scanout over a fresh image.
    preload(2);
    for (int l = 0; l < 3; l++) begin
      int y;
      y = $urandom_range(0, H * SC - 1);
      for (int x = 0; x < W * SC; x++) drive_pix(x, y);
    end
    for (int i = 0; i < 500; i++) begin
      int x, y;
      x = ($urandom_range(0, 9) == 0) ? BLANK : $urandom_range(0, 850);
      y = ($urandom_range(0, 9) == 0) ? BLANK : $urandom_range(0, 620);
      drive_pix(x, y);
    end
    drive_pix(796, 596);
    drive_pix(799, 599);
    drive_pix(800, 0);
    drive_pix(0, 600);
    drive_pix(0, 0);
    drive_pix(1023, 0);
    drive_pix(796, 599);
    blank_cycles(5);

    // Write raised in a fetch cycle: fetch first, write in the next slot.
    for (int x = 0; x < W * SC; x++) begin
      drive_pix(x, 40);
      if (x == 16) begin
        wr_req  = 1'b1;
        wr_addr = 15'd5;
        wr_data = 12'h123;
        wr_q.push_back('{5, 12'h123});
        ovr[5] = 12'h123;
      end else if (x == 17) begin
        @(negedge clk);
        check("contend_fetch_first", {ram_en, ram_we, ram_addr}, {17'd0, 2'b10, 15'd2004});
      end else if (x == 18) begin
        wr_req = 1'b0;
        @(negedge clk);
        check("contend_write_slot", {wr_ack, ram_we, ram_addr}, {17'd0, 2'b11, 15'd5});
      end
    end
    blank_cycles(5);
    check("contend_mem5", {20'd0, mem[5]}, 32'h123);

    // Back-to-back writes during blanking with wr_req held.
    preload(3);
    base = $urandom_range(0, WORDS - 40);
    for (int i = 0; i < 6; i++) begin
      addrs[i] = base + i * 3;
      datas[i] = 12'($urandom);
    end
    first_ack = 0;
    for (int i = 0; i < 6; i++) begin
      issue(addrs[i], datas[i], 10);
      if (i == 0) first_ack = last_ack_cyc;
    end
    wr_req = 1'b0;
    check("b2b_span", 32'(last_ack_cyc - first_ack), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("b2b_once", wcount[addrs[i]], 32'd1);
      check("b2b_data", {20'd0, mem[addrs[i]]}, {20'd0, datas[i]});
    end

    // Out-of-range writes are acked and dropped.
    issue(30000, 12'hFFF, 10);
    issue(32767, 12'hEEE, 10);
    wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fill with a simultaneous game write that must wait for the fill.
    ovr.delete();
    filled      = 1'b1;
    fill_col    = 12'h0F0;
    clear_color = 12'h0F0;
    clear_req   = 1'b1;
    busy_cycles = 0;
    fall_cyc    = 0;
    fork
      issue(9, 12'h999, 40000);
      begin
        @(posedge clk);
        #1 clear_req = 1'b0;
        while (1) begin
          @(negedge clk);
          if (!clear_busy) break;
          busy_cycles++;
          if (busy_cycles > 35000) begin
            total++;
            bad++;
            $display("FAIL clear_timeout: clear_busy still high after %0d cycles", busy_cycles);
            break;
          end
        end
        fall_cyc = cyc;
      end
    join
    wr_req = 1'b0;
    check("clear_busy_cycles", busy_cycles, 32'd30000);
    check("deferred_ack_cycle", 32'(last_ack_cyc - fall_cyc), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_word(i)) mism++;
    check("clear_contents", mism, 32'd0);

    // Scanout of the filled frame.
    for (int i = 0; i < 60; i++) drive_pix($urandom_range(0, 90), $urandom_range(0, 12));
    blank_cycles(5);

    // Reset in the middle of a fill aborts it at once.
    clear_color = 12'h00F;
    clear_req   = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midclear_busy", {31'd0, clear_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_abort_busy", {31'd0, clear_busy}, 32'd0);
    check("reset_abort_ram", {30'd0, ram_en, ram_we}, 32'd0);
    check("reset_abort_out", {20'd0, out_r, out_g, out_b}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", {31'd0, clear_busy}, 32'd0);

    check("pix_queue_drained", pix_q.size(), 32'd0);
    check("wr_queue_drained", wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
